// File: rtl/mfb_frame_checker.sv
// ============================================================================
// Module   : mfb_frame_checker
// Brief    : MFB sink that measures frame lengths, flags length and SOF/EOF
//            framing errors and keeps saturating statistics counters.
//            Optional LFSR back-pressure: MFB_FRAME_CHECKER_BACKPRESSURE_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mfb_frame_checker #(
  parameter int REGIONS        = 4,
  parameter int REGION_SIZE    = 8,
  parameter int BLOCK_SIZE     = 8,
  parameter int ITEM_WIDTH     = 8,
  parameter int FRAME_SIZE_MIN = 60,
  parameter int FRAME_SIZE_MAX = 512,
  parameter int LEN_WIDTH      = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                                                 clk,
  input  logic                                                 reset_n,
  input  logic [REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0] rx_data,
  input  logic [REGIONS*$clog2(REGION_SIZE)-1:0]               rx_sof_pos,
  input  logic [REGIONS*$clog2(REGION_SIZE*BLOCK_SIZE)-1:0]    rx_eof_pos,
  input  logic [REGIONS-1:0]                                   rx_sof,
  input  logic [REGIONS-1:0]                                   rx_eof,
  input  logic                                                 rx_src_rdy,
  output logic                                                 rx_dst_rdy,
  input  logic                                                 clear,
  output logic [CNT_WIDTH-1:0]                                 frame_cnt,
  output logic [CNT_WIDTH-1:0]                                 len_err_cnt,
  output logic [CNT_WIDTH-1:0]                                 proto_err_cnt,
  output logic [LEN_WIDTH-1:0]                                 last_len,
  output logic                                                 err
);

  localparam int SOF_W = $clog2(REGION_SIZE);
  localparam int EOF_W = $clog2(REGION_SIZE*BLOCK_SIZE);
  localparam int EVW   = $clog2(REGIONS+1);

  localparam logic [LEN_WIDTH-1:0] REGION_ITEMS = LEN_WIDTH'(REGION_SIZE*BLOCK_SIZE);
  localparam logic [LEN_WIDTH-1:0] BLK_ITEMS    = LEN_WIDTH'(BLOCK_SIZE);
  localparam logic [LEN_WIDTH-1:0] LEN_MIN      = LEN_WIDTH'(FRAME_SIZE_MIN);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX      = LEN_WIDTH'(FRAME_SIZE_MAX);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE      = LEN_WIDTH'(1);

  typedef struct packed {
    logic                 in_frame;
    logic [LEN_WIDTH-1:0] acc;
    logic                 closed;
    logic [LEN_WIDTH-1:0] last_len;
    logic [EVW-1:0]       frames;
    logic [EVW-1:0]       len_errs;
    logic [EVW-1:0]       proto_errs;
  } word_eval_t;

  logic                 rdy_q;
  logic                 in_frame;
  logic [LEN_WIDTH-1:0] acc;
  logic                 xfer;
  word_eval_t           ev;
  logic                 unused_data;

  function automatic logic [LEN_WIDTH-1:0] len_add(input logic [LEN_WIDTH-1:0] a,
                                                   input logic [LEN_WIDTH-1:0] b);
    logic [LEN_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : s[LEN_WIDTH-1:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_add(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [EVW-1:0]       inc);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, c} + {{(CNT_WIDTH+1-EVW){1'b0}}, inc};
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  // Walks regions 0..REGIONS-1, chaining frame state; closing a frame never
  // touches in_frame/acc, so it is applied after the region's SOF handling.
  function automatic word_eval_t eval_word(
    input logic                             in_frame_i,
    input logic [LEN_WIDTH-1:0]             acc_i,
    input logic [REGIONS-1:0]               sof,
    input logic [REGIONS-1:0]               eof,
    input logic [REGIONS*SOF_W-1:0]         sof_pos,
    input logic [REGIONS*EOF_W-1:0]         eof_pos
  );
    word_eval_t           res;
    logic [LEN_WIDTH-1:0] sp;
    logic [LEN_WIDTH-1:0] ep;
    logic [LEN_WIDTH-1:0] len;
    logic                 close;
    res          = '0;
    res.in_frame = in_frame_i;
    res.acc      = acc_i;
    for (int r = 0; r < REGIONS; r++) begin
      sp    = LEN_WIDTH'(sof_pos[r*SOF_W +: SOF_W]) * BLK_ITEMS;
      ep    = LEN_WIDTH'(eof_pos[r*EOF_W +: EOF_W]);
      close = 1'b0;
      len   = '0;
      if (sof[r] && eof[r] && (sp <= ep)) begin
        if (res.in_frame) res.proto_errs = res.proto_errs + EVW'(1);
        close        = 1'b1;
        len          = ep - sp + LEN_ONE;
        res.in_frame = 1'b0;
      end else begin
        if (eof[r]) begin
          if (res.in_frame) begin
            close = 1'b1;
            len   = len_add(res.acc, ep + LEN_ONE);
          end else begin
            res.proto_errs = res.proto_errs + EVW'(1);
          end
          res.in_frame = 1'b0;
        end
        if (sof[r]) begin
          if (res.in_frame) res.proto_errs = res.proto_errs + EVW'(1);
          res.in_frame = 1'b1;
          res.acc      = REGION_ITEMS - sp;
        end else if (res.in_frame) begin
          res.acc = len_add(res.acc, REGION_ITEMS);
        end
      end
      if (close) begin
        res.frames   = res.frames + EVW'(1);
        res.closed   = 1'b1;
        res.last_len = len;
        if ((len < LEN_MIN) || (len > LEN_MAX) || (len == {LEN_WIDTH{1'b1}}))
          res.len_errs = res.len_errs + EVW'(1);
      end
    end
    return res;
  endfunction

  assign unused_data = ^rx_data;
  assign xfer        = rx_src_rdy & rx_dst_rdy;
  assign ev          = eval_word(in_frame, acc, rx_sof, rx_eof, rx_sof_pos, rx_eof_pos);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdy_q         <= 1'b0;
      in_frame      <= 1'b0;
      acc           <= '0;
      frame_cnt     <= '0;
      len_err_cnt   <= '0;
      proto_err_cnt <= '0;
      last_len      <= '0;
      err           <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (xfer) begin
        in_frame <= ev.in_frame;
        acc      <= ev.acc;
      end
      if (clear) begin
        frame_cnt     <= '0;
        len_err_cnt   <= '0;
        proto_err_cnt <= '0;
        last_len      <= '0;
        err           <= 1'b0;
      end else if (xfer) begin
        frame_cnt     <= cnt_add(frame_cnt, ev.frames);
        len_err_cnt   <= cnt_add(len_err_cnt, ev.len_errs);
        proto_err_cnt <= cnt_add(proto_err_cnt, ev.proto_errs);
        if (ev.closed) last_len <= ev.last_len;
        if ((ev.len_errs != '0) || (ev.proto_errs != '0)) err <= 1'b1;
      end
    end
  end

`ifdef MFB_FRAME_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // Fibonacci taps 16,14,13,11; stalls whenever the two LSBs are zero.
  always_ff @(posedge clk) begin
    if (!reset_n) lfsr <= 16'hACE1;
    else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign rx_dst_rdy = rdy_q & (lfsr[1:0] != 2'b00);
`else
  assign rx_dst_rdy = rdy_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mfb_frame_checker.sv
// ============================================================================
// Module   : tb_mfb_frame_checker
// Brief    : Directed table plus random words against an item-position model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mfb_frame_checker;

  localparam int REGIONS = 4;
  localparam int FMIN    = 60;
  localparam int FMAX    = 512;
  localparam int DW      = 4*8*8*8;

  typedef struct packed {
    logic [3:0]  sof;
    logic [3:0]  eof;
    logic [11:0] sp;
    logic [23:0] ep;
  } word_t;

  typedef struct {
    word_t w;
    bit    clr;
    int    fc;
    int    lec;
    int    pec;
    int    ll;
    bit    er;
  } vec_t;

  logic          clk;
  logic          reset_n;
  logic [DW-1:0] rx_data;
  logic [11:0]   rx_sof_pos;
  logic [23:0]   rx_eof_pos;
  logic [3:0]    rx_sof;
  logic [3:0]    rx_eof;
  logic          rx_src_rdy;
  logic          rx_dst_rdy;
  logic          clear;
  logic [31:0]   frame_cnt;
  logic [31:0]   len_err_cnt;
  logic [31:0]   proto_err_cnt;
  logic [15:0]   last_len;
  logic          err;

  mfb_frame_checker dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_data       (rx_data),
    .rx_sof_pos    (rx_sof_pos),
    .rx_eof_pos    (rx_eof_pos),
    .rx_sof        (rx_sof),
    .rx_eof        (rx_eof),
    .rx_src_rdy    (rx_src_rdy),
    .rx_dst_rdy    (rx_dst_rdy),
    .clear         (clear),
    .frame_cnt     (frame_cnt),
    .len_err_cnt   (len_err_cnt),
    .proto_err_cnt (proto_err_cnt),
    .last_len      (last_len),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc_total = 0;
  int cyc_stall = 0;

  // Reference model: frames tracked by absolute item position in the stream.
  bit          m_in;
  longint      m_start;
  longint      m_base;
  int unsigned m_fc, m_lec, m_pec, m_ll;
  bit          m_err;

  function automatic void m_reset();
    m_in = 0; m_start = 0;
    m_fc = 0; m_lec = 0; m_pec = 0; m_ll = 0; m_err = 0;
  endfunction

  function automatic void m_clear();
    m_fc = 0; m_lec = 0; m_pec = 0; m_ll = 0; m_err = 0;
  endfunction

  function automatic void m_sof(longint p);
    if (m_in) begin m_pec++; m_err = 1; end
    m_in    = 1;
    m_start = p;
  endfunction

  function automatic void m_eof(longint p);
    longint len;
    if (!m_in) begin
      m_pec++; m_err = 1;
    end else begin
      len = p - m_start + 1;
      if (len > 65535) len = 65535;
      m_fc++;
      m_ll = int'(len);
      if (len < FMIN || len > FMAX) begin m_lec++; m_err = 1; end
    end
    m_in = 0;
  endfunction

  function automatic void m_word(word_t w);
    longint rb, s_at, e_at;
    for (int r = 0; r < REGIONS; r++) begin
      rb   = m_base + r*64;
      s_at = rb + 8*longint'(w.sp[r*3 +: 3]);
      e_at = rb + longint'(w.ep[r*6 +: 6]);
      if (w.sof[r] && w.eof[r] && s_at <= e_at) begin
        m_sof(s_at); m_eof(e_at);
      end else begin
        if (w.eof[r]) m_eof(e_at);
        if (w.sof[r]) m_sof(s_at);
      end
    end
    m_base += 256;
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  task automatic check_outs(string tag, int fc, int lec, int pec, int ll, bit er);
    chk({tag, ".frame_cnt"},     64'(frame_cnt),     64'(fc));
    chk({tag, ".len_err_cnt"},   64'(len_err_cnt),   64'(lec));
    chk({tag, ".proto_err_cnt"}, 64'(proto_err_cnt), 64'(pec));
    chk({tag, ".last_len"},      64'(last_len),      64'(ll));
    chk({tag, ".err"},           64'(err),           64'(er));
  endtask

  task automatic check_model(string tag);
    check_outs(tag, int'(m_fc), int'(m_lec), int'(m_pec), int'(m_ll), m_err);
  endtask

  // Holds the word until accepted; clear is asserted only on the first cycle.
  task automatic apply(word_t w, bit clr);
    bit got;
    int waits;
    got   = 0;
    waits = 0;
    @(negedge clk);
    rx_sof     = w.sof;
    rx_eof     = w.eof;
    rx_sof_pos = w.sp;
    rx_eof_pos = w.ep;
    rx_data    = {64{$urandom()}};
    rx_src_rdy = 1'b1;
    clear      = clr;
    while (!got && waits < 64) begin
      got = rx_dst_rdy;
      cyc_total++;
      if (!got) cyc_stall++;
      @(posedge clk);
      if (got) m_word(w);
      if (clear) m_clear();
      @(negedge clk);
      clear = 1'b0;
      waits++;
    end
    rx_src_rdy = 1'b0;
    rx_sof     = 4'($urandom());
    rx_eof     = 4'($urandom());
    rx_sof_pos = 12'($urandom());
    rx_eof_pos = 24'($urandom());
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got rx_dst_rdy=0 for 64 cycles expected 1");
    end
  endtask

  function automatic logic [11:0] sp4(int a0, int a1, int a2, int a3);
    return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  function automatic logic [23:0] ep4(int a0, int a1, int a2, int a3);
    return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  function automatic vec_t row(logic [3:0] s, logic [3:0] e, logic [11:0] sp, logic [23:0] ep,
                               bit clr, int fc, int lec, int pec, int ll, bit er);
    vec_t v;
    v.w.sof = s; v.w.eof = e; v.w.sp = sp; v.w.ep = ep;
    v.clr = clr; v.fc = fc; v.lec = lec; v.pec = pec; v.ll = ll; v.er = er;
    return v;
  endfunction

  vec_t  tbl[$];
  word_t wr;

  initial begin
    reset_n    = 1'b0;
    rx_src_rdy = 1'b0;
    clear      = 1'b0;
    rx_sof     = '0;
    rx_eof     = '0;
    rx_sof_pos = '0;
    rx_eof_pos = '0;
    rx_data    = '0;
    m_reset();
    m_base = 0;

    //        sof      eof      sof_pos          eof_pos              clr fc lec pec ll  err
    tbl.push_back(row(4'b0000, 4'b0000, sp4(0,0,0,0), ep4(0,0,0,0),   0, 0, 0, 0, 0,   0));
    tbl.push_back(row(4'b0001, 4'b0001, sp4(0,0,0,0), ep4(59,0,0,0),  0, 1, 0, 0, 60,  0));
    tbl.push_back(row(4'b0001, 4'b0000, sp4(0,0,0,0), ep4(0,0,0,0),   0, 1, 0, 0, 60,  0));
    tbl.push_back(row(4'b0000, 4'b1000, sp4(0,0,0,0), ep4(0,0,0,63),  0, 2, 0, 0, 512, 0));
    tbl.push_back(row(4'b0001, 4'b0001, sp4(0,0,0,0), ep4(58,0,0,0),  0, 3, 1, 0, 59,  1));
    tbl.push_back(row(4'b0001, 4'b0000, sp4(0,0,0,0), ep4(0,0,0,0),   0, 3, 1, 0, 59,  1));
    tbl.push_back(row(4'b0000, 4'b0000, sp4(0,0,0,0), ep4(0,0,0,0),   0, 3, 1, 0, 59,  1));
    tbl.push_back(row(4'b0000, 4'b0001, sp4(0,0,0,0), ep4(0,0,0,0),   0, 4, 2, 0, 513, 1));
    tbl.push_back(row(4'b0000, 4'b0000, sp4(0,0,0,0), ep4(0,0,0,0),   1, 0, 0, 0, 0,   0));
    tbl.push_back(row(4'b0011, 4'b0010, sp4(0,2,0,0), ep4(0,9,0,0),   0, 1, 0, 0, 74,  0));
    tbl.push_back(row(4'b0000, 4'b0001, sp4(0,0,0,0), ep4(23,0,0,0),  0, 2, 0, 0, 200, 0));
    tbl.push_back(row(4'b0101, 4'b0000, sp4(0,0,1,0), ep4(0,0,0,0),   0, 2, 0, 1, 200, 1));
    tbl.push_back(row(4'b0000, 4'b1010, sp4(0,0,0,0), ep4(0,9,0,5),   0, 3, 0, 2, 194, 1));
    tbl.push_back(row(4'b0001, 4'b0001, sp4(1,0,0,0), ep4(63,0,0,0),  1, 0, 0, 0, 0,   0));
    tbl.push_back(row(4'b1000, 4'b0000, sp4(0,0,0,4), ep4(0,0,0,0),   0, 0, 0, 0, 0,   0));
    tbl.push_back(row(4'b0011, 4'b0011, sp4(0,7,0,0), ep4(63,55,0,0), 0, 1, 0, 2, 64,  1));
    tbl.push_back(row(4'b0000, 4'b0001, sp4(0,0,0,0), ep4(0,0,0,0),   0, 2, 0, 2, 137, 1));

    repeat (3) @(negedge clk);
    chk("reset.dst_rdy", 64'(rx_dst_rdy), 64'd0);
    check_outs("reset", 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    @(negedge clk);
`ifndef MFB_FRAME_CHECKER_BACKPRESSURE_EN
    chk("release.dst_rdy", 64'(rx_dst_rdy), 64'd1);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].w, tbl[i].clr);
      check_outs($sformatf("row%0d", i), tbl[i].fc, tbl[i].lec, tbl[i].pec, tbl[i].ll, tbl[i].er);
    end

    // Reset in the middle of an open frame must discard it.
    wr = '{sof: 4'b0100, eof: 4'b0000, sp: sp4(0,0,0,0), ep: ep4(0,0,0,0)};
    apply(wr, 0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid.dst_rdy", 64'(rx_dst_rdy), 64'd0);
    check_outs("rst_mid", 0, 0, 0, 0, 0);
    m_reset();
    reset_n = 1'b1;
    @(negedge clk);
    wr = '{sof: 4'b0000, eof: 4'b0001, sp: sp4(0,0,0,0), ep: ep4(10,0,0,0)};
    apply(wr, 0);
    check_outs("rst_mid.eof", 0, 0, 1, 0, 1);

    cyc_total = 0;
    cyc_stall = 0;
    for (int i = 0; i < 3000; i++) begin
      wr.sof = 4'($urandom() & $urandom());
      wr.eof = 4'($urandom() & $urandom());
      wr.sp  = 12'($urandom());
      wr.ep  = 24'($urandom());
      apply(wr, $urandom_range(0, 31) == 0);
      check_model($sformatf("rand%0d", i));
    end

`ifdef MFB_FRAME_CHECKER_BACKPRESSURE_EN
    chk("stall_ratio_in_15_35pct",
        64'((cyc_stall*100 >= cyc_total*15) && (cyc_stall*100 <= cyc_total*35)), 64'd1);
`else
    chk("stall_cycles", 64'(cyc_stall), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
